// File: rtl/aligned_ram_pkg.sv
// rtl/aligned_ram_pkg.sv - shared types for the aligned RAM read and write paths
package aligned_ram_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/aligned_load_extract.sv
// rtl/aligned_load_extract.sv - lane select and zero/sign extension of a loaded word
module aligned_load_extract
  import aligned_ram_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [WORD_W-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_B:    data = {{24{sext & lane_b[7]}}, lane_b};
      SZ_H:    data = {{16{sext & lane_h[15]}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/aligned_ram_reader.sv
// rtl/aligned_ram_reader.sv - checked byte/half/word loads from a fixed-latency RAM
module aligned_ram_reader
  import aligned_ram_pkg::*;
#(
  parameter  int DEPTH   = 256,
  parameter  int MEM_LAT = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] rdata,
  output logic              error,
  output logic [15:0]       err_cnt
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [7:0]  LAT_LAST   = 8'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [AW+1:0]       addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [7:0]          lat_cnt_q, lat_cnt_d;
  logic                cap_q, cap_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                error_q, error_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                req_err;
  logic [WORD_W-1:0]   ext_data;

  aligned_load_extract u_extract (
    .word    (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .sext    (sext_q),
    .data    (ext_data)
  );

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = req_addr[0];
      SZ_W:    req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr >= ADDR_LIMIT) req_err = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sext_d      = sext_q;
    mem_rd_en_d = 1'b0;
    lat_cnt_d   = lat_cnt_q;
    cap_d       = 1'b0;
    rdata_d     = rdata_q;
    error_d     = error_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr[AW+1:0];
          size_d = req_size;
          sext_d = req_signed;
          if (req_err) begin
            state_d = RESP;
            error_d = 1'b1;
            rdata_d = '0;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            state_d     = MEM;
            mem_rd_en_d = 1'b1;
            lat_cnt_d   = '0;
            error_d     = 1'b0;
          end
        end
      end
      // Leave MEM one cycle early so resp_valid coincides with the data cycle;
      // the first RESP cycle forwards the extracted data and registers it.
      MEM: begin
        lat_cnt_d = lat_cnt_q + 8'd1;
        if (lat_cnt_q == LAT_LAST) begin
          state_d = RESP;
          cap_d   = 1'b1;
        end
      end
      RESP: begin
        if (cap_q) rdata_d = ext_data;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      lat_cnt_q   <= '0;
      cap_q       <= 1'b0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      mem_rd_en_q <= mem_rd_en_d;
      lat_cnt_q   <= lat_cnt_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = addr_q[AW+1:2];
  assign resp_valid = (state_q == RESP);
  assign rdata      = cap_q ? ext_data : rdata_q;
  assign error      = error_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_aligned_ram_reader.sv
// tb/tb_aligned_ram_reader.sv - table and randomized checks of aligned_ram_reader at two latencies
module tb_aligned_ram_reader;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic        mem_rd_en  [2];
  logic [7:0]  mem_addr   [2];
  logic [31:0] mem_rdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] rdata      [2];
  logic        error      [2];
  logic [15:0] err_cnt    [2];

  aligned_ram_reader #(.DEPTH(DEPTH), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .rdata(rdata[0]),
    .error(error[0]), .err_cnt(err_cnt[0])
  );

  aligned_ram_reader #(.DEPTH(DEPTH), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .rdata(rdata[1]),
    .error(error[1]), .err_cnt(err_cnt[1])
  );

  int checks = 0;
  int errors = 0;
  int err_model [2];

  logic [31:0] ram [DEPTH];
  int          cyc = 0;
  int          due [2];
  logic [31:0] pend [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // RAM model: data only valid exactly lat cycles after the strobe, noise otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (mem_rd_en[k]) begin
        due[k]  <= cyc + lat_of(k);
        pend[k] <= ram[mem_addr[k]];
      end
      if (mem_rd_en[k] && lat_of(k) == 1) mem_rdata[k] <= ram[mem_addr[k]];
      else if (due[k] == cyc + 1)          mem_rdata[k] <= pend[k];
      else                                 mem_rdata[k] <= $urandom;
    end
  end

  function automatic logic [32:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic sgn);
    int unsigned nbytes;
    logic [31:0] word, val, mask;
    if (size == 2'd3) return {1'b1, 32'h0};
    nbytes = 32'd1 << size;
    if ((addr % nbytes) != 0 || addr >= 32'(4 * DEPTH)) return {1'b1, 32'h0};
    word = ram[8'(addr / 4)];
    val  = word >> (8 * (addr % 4));
    if (nbytes == 4) return {1'b0, val};
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    val  = val & mask;
    if (sgn && val[8 * nbytes - 1]) val = val | ~mask;
    return {1'b0, val};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic req_run(input int k, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic exp_err, input logic [31:0] exp_data,
                         input int hold, input logic intrude);
    int n, rd_cnt, rd_at, rv_at;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_before[%0d]", k), 32'(req_ready[k]), 32'd1);
    req_valid[k]  = 1'b1;
    req_addr[k]   = addr;
    req_size[k]   = size;
    req_signed[k] = sgn;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = $urandom;
    req_size[k]  = 2'($urandom);
    if (exp_err) err_model[k]++;
    rd_cnt = 0;
    rd_at  = 0;
    rv_at  = 0;
    for (n = 1; n <= 20 && rv_at == 0; n++) begin
      @(negedge clk);
      if (mem_rd_en[k]) begin
        rd_cnt++;
        rd_at = n;
        check($sformatf("mem_addr[%0d] a=%h", k, addr), 32'(mem_addr[k]), 32'(addr[9:2]));
      end
      if (resp_valid[k]) rv_at = n;
    end
    check($sformatf("rd_en_count[%0d] a=%h", k, addr), 32'(rd_cnt), exp_err ? 32'd0 : 32'd1);
    check($sformatf("rd_en_cycle[%0d] a=%h", k, addr), 32'(rd_at), exp_err ? 32'd0 : 32'd1);
    check($sformatf("resp_cycle[%0d] a=%h", k, addr), 32'(rv_at),
          exp_err ? 32'd1 : 32'(lat_of(k) + 1));
    check($sformatf("rdata[%0d] a=%h sz=%0d s=%0d", k, addr, size, sgn), rdata[k], exp_data);
    check($sformatf("error[%0d] a=%h", k, addr), 32'(error[k]), 32'(exp_err));
    check($sformatf("err_cnt[%0d]", k), 32'(err_cnt[k]), 32'(err_model[k]));
    for (int h = 0; h < hold; h++) begin
      if (intrude) begin
        req_valid[k] = 1'b1;
        req_addr[k]  = 32'h10;
        req_size[k]  = 2'd2;
      end
      @(negedge clk);
      check($sformatf("hold_valid[%0d]", k), 32'(resp_valid[k]), 32'd1);
      check($sformatf("hold_rdata[%0d]", k), rdata[k], exp_data);
      check($sformatf("hold_error[%0d]", k), 32'(error[k]), 32'(exp_err));
      check($sformatf("hold_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
      check($sformatf("hold_rd_en[%0d]", k), 32'(mem_rd_en[k]), 32'd0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    @(negedge clk);
    check($sformatf("post_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
    check($sformatf("post_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
    check($sformatf("post_rd_en[%0d]", k), 32'(mem_rd_en[k]), 32'd0);
  endtask

  task automatic random_phase(input int k, input int count);
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [32:0] e;
    for (int i = 0; i < count; i++) begin
      addr = 32'($urandom_range(0, 1100));
      size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
      sgn = 1'($urandom);
      e   = ref_load(addr, size, sgn);
      req_run(k, addr, size, sgn, e[32], e[31:0], $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  typedef struct {
    int          widx;
    logic [31:0] wval;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1,   32'hDEADBEEF, 32'h004, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1,   32'h000080FF, 32'h005, 2'd0, 1'b1, 1'b0, 32'hFFFFFF80};
    vecs[2]  = '{1,   32'h000080FF, 32'h005, 2'd0, 1'b0, 1'b0, 32'h00000080};
    vecs[3]  = '{1,   32'h000080FF, 32'h006, 2'd1, 1'b1, 1'b0, 32'h00000000};
    vecs[4]  = '{1,   32'h000080FF, 32'h004, 2'd1, 1'b1, 1'b0, 32'hFFFF80FF};
    vecs[5]  = '{1,   32'hDEADBEEF, 32'h007, 2'd0, 1'b0, 1'b0, 32'h000000DE};
    vecs[6]  = '{1,   32'hDEADBEEF, 32'h006, 2'd1, 1'b1, 1'b0, 32'hFFFFDEAD};
    vecs[7]  = '{1,   32'hDEADBEEF, 32'h004, 2'd2, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[8]  = '{1,   32'hDEADBEEF, 32'h005, 2'd2, 1'b0, 1'b1, 32'h00000000};
    vecs[9]  = '{1,   32'hDEADBEEF, 32'h003, 2'd1, 1'b0, 1'b1, 32'h00000000};
    vecs[10] = '{1,   32'hDEADBEEF, 32'h004, 2'd3, 1'b0, 1'b1, 32'h00000000};
    vecs[11] = '{1,   32'hDEADBEEF, 32'h400, 2'd2, 1'b0, 1'b1, 32'h00000000};
    vecs[12] = '{255, 32'h80C1A2F3, 32'h3FF, 2'd0, 1'b1, 1'b0, 32'hFFFFFF80};
    vecs[13] = '{255, 32'h80C1A2F3, 32'h3FE, 2'd1, 1'b0, 1'b0, 32'h000080C1};
    vecs[14] = '{255, 32'h80C1A2F3, 32'h3FC, 2'd2, 1'b0, 1'b0, 32'h80C1A2F3};

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    for (int k = 0; k < 2; k++) begin
      rst[k]        = 1'b1;
      req_valid[k]  = 1'b0;
      req_addr[k]   = '0;
      req_size[k]   = '0;
      req_signed[k] = 1'b0;
      resp_ready[k] = 1'b0;
      err_model[k]  = 0;
      due[k]        = -10;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
      check($sformatf("rst_rdata[%0d]", k), rdata[k], 32'd0);
      check($sformatf("rst_error[%0d]", k), 32'(error[k]), 32'd0);
      check($sformatf("rst_rd_en[%0d]", k), 32'(mem_rd_en[k]), 32'd0);
      check($sformatf("rst_err_cnt[%0d]", k), 32'(err_cnt[k]), 32'd0);
      check($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
      rst[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("idle_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);

    for (int i = 0; i < 15; i++) begin
      ram[vecs[i].widx] = vecs[i].wval;
      req_run(0, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].err, vecs[i].data,
              i % 4, 1'(i % 2));
    end
    check("table_err_cnt", 32'(err_cnt[0]), 32'd4);

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    random_phase(0, 60);

    // Latency-3 instance: three back-to-back word reads of 0x8, each at the earliest slot
    for (int i = 0; i < 3; i++) begin
      ram[2] = $urandom;
      req_run(1, 32'h8, 2'd2, 1'b0, 1'b0, ram[2], 0, 1'b0);
    end
    random_phase(1, 30);

    ram[2] = 32'hCAFEF00D;
    req_valid[1]  = 1'b1;
    req_addr[1]   = 32'h8;
    req_size[1]   = 2'd2;
    req_signed[1] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("mid_rst_rd_en", 32'(mem_rd_en[1]), 32'd1);
    @(negedge clk);
    check("mid_rst_busy_valid", 32'(resp_valid[1]), 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready[1]), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt[1]), 32'd0);
    rst[1]       = 1'b0;
    err_model[1] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("after_rst_valid_%0d", i), 32'(resp_valid[1]), 32'd0);
      check($sformatf("after_rst_rdata_%0d", i), rdata[1], 32'd0);
      check($sformatf("after_rst_ready_%0d", i), 32'(req_ready[1]), 32'd1);
    end
    req_run(1, 32'h8, 2'd2, 1'b0, 1'b0, 32'hCAFEF00D, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
